// File: rtl/high_priority_cc_v2.sv
// high_priority_cc_v2: high-priority command-and-control frame decoder for an SDR radio.
// Parses UDP payload frames addressed to PORT into shadow registers and commits them all
// to the outputs at once when byte 1443 has been received. Truncated frames are discarded.
// Ports: clk/rst (async active-high); to_port, udp_rx_active, udp_rx_data frame stream;
//        HW_timeout host watchdog; radio control outputs (run, PC_PTT, CWX/Dot/Dash,
//        Rx/Tx frequencies, drive levels, Alex, attenuators, GPIO bytes); update_strobe,
//        short_frame, seq_error pulses; seq_error_count; HW_reset payload-in-progress.
// Optional feature: define SEQ_CHECK_EN to enable frame sequence-number checking.
module high_priority_cc_v2 #(
    parameter logic [15:0] PORT = 16'd1027,
    parameter int          NR   = 8,
    parameter int          NT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       to_port,
    input  logic              udp_rx_active,
    input  logic [7:0]        udp_rx_data,
    input  logic              HW_timeout,
    output logic              run,
    output logic [NT-1:0]     PC_PTT,
    output logic              CWX,
    output logic              Dot,
    output logic              Dash,
    output logic [32*NR-1:0]  Rx_frequency,
    output logic [32*NT-1:0]  Tx_frequency,
    output logic [8*NT-1:0]   drive_level,
    output logic [47:0]       Alex_data,
    output logic [4:0]        Attenuator0,
    output logic [4:0]        Attenuator1,
    output logic [7:0]        Open_Collector,
    output logic [7:0]        User_Outputs,
    output logic [7:0]        Mercury_Attenuator,
    output logic [7:0]        DLE_outputs,
    output logic              update_strobe,
    output logic              short_frame,
    output logic              seq_error,
    output logic [15:0]       seq_error_count,
    output logic              HW_reset
);
    localparam logic [10:0] LAST = 11'd1443;
    // DRAIN swallows any bytes past offset 1443 so a long frame cannot restart the parser
    typedef enum logic [1:0] {IDLE, PAYLOAD, COMMIT, DRAIN} state_t;
    state_t             r_state;
    logic [10:0]        r_offset;
    logic               r_s_run, r_run;
    logic [NT-1:0]      r_s_ptt, r_ptt;
    logic [2:0]         r_s_cw, r_cw;
    logic [32*NR-1:0]   r_s_rx, r_rx;
    logic [32*NT-1:0]   r_s_tx, r_tx;
    logic [8*NT-1:0]    r_s_drv, r_drv;
    logic [47:0]        r_s_alex, r_alex;
    logic [4:0]         r_s_att0, r_att0, r_s_att1, r_att1;
    logic [7:0]         r_s_dle, r_dle, r_s_oc, r_oc, r_s_user, r_user, r_s_merc, r_merc;
    logic               r_strobe, r_short;
    logic               w_start, w_cap;
    logic [10:0]        w_off;
    assign w_start = udp_rx_active && (to_port == PORT);
    // The first byte is captured while still in IDLE, so its offset is forced to 0
    assign w_cap   = (r_state == IDLE) ? w_start : (r_state == PAYLOAD) && udp_rx_active;
    assign w_off   = (r_state == IDLE) ? 11'd0 : r_offset;
    assign HW_reset = (r_state == PAYLOAD) && udp_rx_active && (r_offset > 11'd4);
`ifdef SEQ_CHECK_EN
    logic [31:0] r_s_seq, r_expected;
    logic        r_first, r_seq_error;
    logic [15:0] r_seq_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_seq     <= '0;
            r_expected  <= '0;
            r_first     <= 1'b1;
            r_seq_error <= 1'b0;
            r_seq_cnt   <= '0;
        end else begin
            r_seq_error <= 1'b0;
            for (int b = 0; b < 4; b++)
                if (w_cap && w_off == 11'(b)) r_s_seq[8*(3-b) +: 8] <= udp_rx_data;
            if (r_state == COMMIT) begin
                r_first    <= 1'b0;
                r_expected <= r_s_seq + 32'd1;
                if (!r_first && r_s_seq != r_expected) begin
                    r_seq_error <= 1'b1;
                    r_seq_cnt   <= (r_seq_cnt == 16'hFFFF) ? r_seq_cnt : r_seq_cnt + 16'd1;
                end
            end
        end
    end
    assign seq_error       = r_seq_error;
    assign seq_error_count = r_seq_cnt;
`else
    assign seq_error       = 1'b0;
    assign seq_error_count = '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_s_run, r_s_ptt, r_s_cw, r_s_rx, r_s_tx, r_s_drv} <= '0;
            {r_s_alex, r_s_att0, r_s_att1, r_s_dle, r_s_oc, r_s_user, r_s_merc} <= '0;
        end else if (w_cap) begin
            if (w_off == 11'd4) {r_s_ptt, r_s_run} <= udp_rx_data[NT:0];
            if (w_off == 11'd5) r_s_cw <= udp_rx_data[2:0];
            for (int i = 0; i < NR; i++)
                for (int b = 0; b < 4; b++)
                    if (w_off == 11'(9 + 4*i + b)) r_s_rx[32*i + 8*(3-b) +: 8] <= udp_rx_data;
            for (int k = 0; k < NT; k++) begin
                for (int b = 0; b < 4; b++)
                    if (w_off == 11'(329 + 4*k + b)) r_s_tx[32*k + 8*(3-b) +: 8] <= udp_rx_data;
                if (w_off == 11'(345 + k)) r_s_drv[8*k +: 8] <= udp_rx_data;
            end
            if (w_off == 11'd1400) r_s_dle  <= udp_rx_data;
            if (w_off == 11'd1401) r_s_oc   <= udp_rx_data;
            if (w_off == 11'd1402) r_s_user <= udp_rx_data;
            if (w_off == 11'd1403) r_s_merc <= udp_rx_data;
            for (int b = 0; b < 6; b++)
                if (w_off == 11'(1430 + b)) r_s_alex[8*(5-b) +: 8] <= udp_rx_data;
            if (w_off == 11'd1442) r_s_att1 <= udp_rx_data[4:0];
            if (w_off == LAST)     r_s_att0 <= udp_rx_data[4:0];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_offset <= '0;
            {r_run, r_ptt, r_cw, r_rx, r_tx, r_drv} <= '0;
            {r_alex, r_att0, r_att1, r_dle, r_oc, r_user, r_merc} <= '0;
            r_strobe <= 1'b0;
            r_short  <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_short  <= 1'b0;
            unique case (r_state)
                IDLE: if (w_start) begin
                    r_state  <= PAYLOAD;
                    r_offset <= 11'd1;
                end
                PAYLOAD: if (!udp_rx_active) begin
                    r_state  <= IDLE;
                    r_offset <= '0;
                    r_short  <= 1'b1;
                end else if (r_offset == LAST) r_state <= COMMIT;
                else r_offset <= r_offset + 11'd1;
                COMMIT: begin
                    {r_run, r_ptt, r_cw, r_rx, r_tx, r_drv} <= {r_s_run, r_s_ptt, r_s_cw, r_s_rx, r_s_tx, r_s_drv};
                    {r_alex, r_att0, r_att1} <= {r_s_alex, r_s_att0, r_s_att1};
                    {r_dle, r_oc, r_user, r_merc} <= {r_s_dle, r_s_oc, r_s_user, r_s_merc};
                    r_strobe <= 1'b1;
                    r_offset <= '0;
                    r_state  <= udp_rx_active ? DRAIN : IDLE;
                end
                DRAIN: if (!udp_rx_active) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Watchdog wins over a simultaneous commit, but only for run
            if (HW_timeout) r_run <= 1'b0;
        end
    end
    assign run                = r_run;
    assign PC_PTT             = r_ptt;
    assign {Dash, Dot, CWX}   = r_cw;
    assign Rx_frequency       = r_rx;
    assign Tx_frequency       = r_tx;
    assign drive_level        = r_drv;
    assign Alex_data          = r_alex;
    assign Attenuator0        = r_att0;
    assign Attenuator1        = r_att1;
    assign DLE_outputs        = r_dle;
    assign Open_Collector     = r_oc;
    assign User_Outputs       = r_user;
    assign Mercury_Attenuator = r_merc;
    assign update_strobe      = r_strobe;
    assign short_frame        = r_short;
endmodule

// File: tb/tb_high_priority_cc_v2.sv
// tb_high_priority_cc_v2: frame-level model of the command decoder checked every cycle, plus literal checks.
module tb_high_priority_cc_v2;
    localparam int NR = 8;
    localparam int NT = 1;
    localparam logic [15:0] PORT = 16'd1027;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] to_port = '0;
    logic act = 1'b0;
    logic [7:0] data = '0;
    logic hwt = 1'b0;
    logic run, CWX, Dot, Dash, update_strobe, short_frame, seq_error, HW_reset;
    logic [NT-1:0] PC_PTT;
    logic [32*NR-1:0] Rx_frequency;
    logic [32*NT-1:0] Tx_frequency;
    logic [8*NT-1:0] drive_level;
    logic [47:0] Alex_data;
    logic [4:0] Attenuator0, Attenuator1;
    logic [7:0] Open_Collector, User_Outputs, Mercury_Attenuator, DLE_outputs;
    logic [15:0] seq_error_count;
    high_priority_cc_v2 #(.PORT(PORT), .NR(NR), .NT(NT)) dut (
        .clk(clk), .rst(rst), .to_port(to_port), .udp_rx_active(act), .udp_rx_data(data),
        .HW_timeout(hwt), .run(run), .PC_PTT(PC_PTT), .CWX(CWX), .Dot(Dot), .Dash(Dash),
        .Rx_frequency(Rx_frequency), .Tx_frequency(Tx_frequency), .drive_level(drive_level),
        .Alex_data(Alex_data), .Attenuator0(Attenuator0), .Attenuator1(Attenuator1),
        .Open_Collector(Open_Collector), .User_Outputs(User_Outputs),
        .Mercury_Attenuator(Mercury_Attenuator), .DLE_outputs(DLE_outputs),
        .update_strobe(update_strobe), .short_frame(short_frame), .seq_error(seq_error),
        .seq_error_count(seq_error_count), .HW_reset(HW_reset)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    int n_strobe = 0, n_short = 0, n_hwr = 0;
    bit chk_en = 0;
    logic [7:0] fr[1444];
    logic [7:0] fb[1444];
    logic e_run, e_cwx, e_dot, e_dash, e_strobe, e_short, e_serr;
    logic [NT-1:0] e_ptt;
    logic [32*NR-1:0] e_rx;
    logic [32*NT-1:0] e_tx;
    logic [8*NT-1:0] e_drv;
    logic [47:0] e_alex;
    logic [4:0] e_att0, e_att1;
    logic [7:0] e_oc, e_user, e_merc, e_dle;
    logic [15:0] e_scnt;
    int m_st, m_cnt;
    bit m_cd;
`ifdef SEQ_CHECK_EN
    bit m_first;
    logic [31:0] m_exp;
`endif
    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    task automatic do_commit();
`ifdef SEQ_CHECK_EN
        logic [31:0] seq;
        seq = {fb[0], fb[1], fb[2], fb[3]};
        if (!m_first && seq != m_exp) begin
            e_serr = 1'b1;
            if (e_scnt != 16'hFFFF) e_scnt = e_scnt + 16'd1;
        end
        m_first = 0;
        m_exp = seq + 32'd1;
`endif
        e_run = fb[4][0];
        e_ptt = fb[4][NT:1];
        {e_dash, e_dot, e_cwx} = fb[5][2:0];
        for (int i = 0; i < NR; i++) e_rx[32*i +: 32] = {fb[9+4*i], fb[10+4*i], fb[11+4*i], fb[12+4*i]};
        for (int k = 0; k < NT; k++) begin
            e_tx[32*k +: 32] = {fb[329+4*k], fb[330+4*k], fb[331+4*k], fb[332+4*k]};
            e_drv[8*k +: 8] = fb[345+k];
        end
        e_dle = fb[1400]; e_oc = fb[1401]; e_user = fb[1402]; e_merc = fb[1403];
        e_alex = {fb[1430], fb[1431], fb[1432], fb[1433], fb[1434], fb[1435]};
        e_att1 = fb[1442][4:0];
        e_att0 = fb[1443][4:0];
        e_strobe = 1'b1;
    endtask
    // Frame-level model: collects payload bytes, decodes the whole frame one cycle after the last byte
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {e_run, e_cwx, e_dot, e_dash, e_strobe, e_short, e_serr, e_ptt} = '0;
            {e_rx, e_tx, e_drv, e_alex, e_att0, e_att1, e_oc, e_user, e_merc, e_dle, e_scnt} = '0;
            m_st = 0; m_cnt = 0; m_cd = 0;
`ifdef SEQ_CHECK_EN
            m_first = 1; m_exp = '0;
`endif
        end else begin
            e_strobe = 1'b0; e_short = 1'b0; e_serr = 1'b0;
            if (m_cd) begin do_commit(); m_cd = 0; end
            if (hwt) e_run = 1'b0;
            if (m_st == 0) begin
                if (act && to_port == PORT) begin fb[0] = data; m_cnt = 1; m_st = 1; end
            end else if (m_st == 1) begin
                if (!act) begin e_short = 1'b1; m_st = 0; m_cnt = 0; end
                else begin
                    fb[m_cnt] = data;
                    if (m_cnt == 1443) begin m_cd = 1; m_st = 2; end else m_cnt++;
                end
            end else if (!act) m_st = 0;
        end
    end
    always @(negedge clk) begin
        if (update_strobe) n_strobe++;
        if (short_frame) n_short++;
        if (HW_reset) n_hwr++;
        if (chk_en) begin
            chk("run", 256'(run), 256'(e_run));
            chk("PC_PTT", 256'(PC_PTT), 256'(e_ptt));
            chk("cw", 256'({Dash, Dot, CWX}), 256'({e_dash, e_dot, e_cwx}));
            chk("Rx_frequency", 256'(Rx_frequency), 256'(e_rx));
            chk("Tx_frequency", 256'(Tx_frequency), 256'(e_tx));
            chk("drive_level", 256'(drive_level), 256'(e_drv));
            chk("Alex_data", 256'(Alex_data), 256'(e_alex));
            chk("att", 256'({Attenuator1, Attenuator0}), 256'({e_att1, e_att0}));
            chk("gpio", 256'({DLE_outputs, Open_Collector, User_Outputs, Mercury_Attenuator}), 256'({e_dle, e_oc, e_user, e_merc}));
            chk("update_strobe", 256'(update_strobe), 256'(e_strobe));
            chk("short_frame", 256'(short_frame), 256'(e_short));
            chk("seq_error", 256'(seq_error), 256'(e_serr));
            chk("seq_error_count", 256'(seq_error_count), 256'(e_scnt));
            chk("HW_reset", 256'(HW_reset), 256'(m_st == 1 && m_cnt > 4 && act));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        act = 1'b0;
        repeat (n) tick();
    endtask
    task automatic mk(input logic [31:0] seq, input bit r);
        for (int j = 0; j < 1444; j++) fr[j] = 8'($urandom);
        {fr[0], fr[1], fr[2], fr[3]} = seq;
        fr[4][0] = r;
    endtask
    task automatic send(input logic [15:0] port, input int n);
        for (int j = 0; j < n; j++) begin
            to_port = port; act = 1'b1; data = fr[j];
            tick();
        end
    endtask
    task automatic do_reset();
        act = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask
    int s0, sh0, h0;
    initial begin
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1;
        tick();
        chk("reset Rx_frequency", 256'(Rx_frequency), 256'(0));
        chk("reset run", 256'(run), 256'(0));
        chk("reset seq_error_count", 256'(seq_error_count), 256'(0));
        // Full frame with known Rx0 and drive level
        mk(32'd5, 1'b1);
        {fr[9], fr[10], fr[11], fr[12]} = 32'h00D59F80;
        fr[345] = 8'h80;
        s0 = n_strobe;
        send(PORT, 1444);
        act = 1'b0;
        @(negedge clk);
        chk("strobe in commit cycle", 256'(update_strobe), 256'(0));
        @(negedge clk);
        chk("strobe one cycle later", 256'(update_strobe), 256'(1));
        idle(4);
        chk("A Rx0", 256'(Rx_frequency[31:0]), 256'(32'h00D59F80));
        chk("A drive_level", 256'(drive_level), 256'(8'h80));
        chk("A run", 256'(run), 256'(1));
        chk("A strobe count", 256'(n_strobe - s0), 256'(1));
        // Truncated frame: discarded
        mk(32'd99, 1'b0);
        s0 = n_strobe; sh0 = n_short;
        send(PORT, 700);
        idle(4);
        chk("short strobe count", 256'(n_strobe - s0), 256'(0));
        chk("short pulse count", 256'(n_short - sh0), 256'(1));
        chk("short Rx0 held", 256'(Rx_frequency[31:0]), 256'(32'h00D59F80));
        // Wrong port: ignored
        mk(32'd6, 1'b0);
        s0 = n_strobe; h0 = n_hwr;
        send(16'd1025, 1444);
        idle(4);
        chk("port1025 strobe", 256'(n_strobe - s0), 256'(0));
        chk("port1025 HW_reset", 256'(n_hwr - h0), 256'(0));
        chk("port1025 run held", 256'(run), 256'(1));
        // Sequence 6 then 8 (gap)
        mk(32'd6, 1'b1); send(PORT, 1444); idle(4);
        mk(32'd8, 1'b1); send(PORT, 1460); idle(4);
`ifdef SEQ_CHECK_EN
        chk("seq 5,6,8 count", 256'(seq_error_count), 256'(1));
`else
        chk("seq count tied", 256'(seq_error_count), 256'(0));
`endif
        // Wraparound after reset: no error
        do_reset();
        mk(32'hFFFFFFFF, 1'b1); send(PORT, 1444); idle(4);
        mk(32'h0, 1'b1); send(PORT, 1444); idle(4);
        chk("wrap count", 256'(seq_error_count), 256'(0));
        chk("run before timeout", 256'(run), 256'(1));
        // Watchdog during the commit cycle wins for run
        mk(32'h1, 1'b1);
        send(PORT, 1444);
        act = 1'b0; hwt = 1'b1;
        tick();
        hwt = 1'b0;
        idle(3);
        chk("timeout run", 256'(run), 256'(0));
        chk("timeout still committed drive", 256'(drive_level), 256'(fr[345]));
        // Reset mid-frame at offset 800
        mk(32'h2, 1'b1);
        send(PORT, 800);
        rst = 1'b1; act = 1'b0;
        #1;
        chk("midreset Rx_frequency", 256'(Rx_frequency), 256'(0));
        chk("midreset Alex_data", 256'(Alex_data), 256'(0));
        tick();
        rst = 1'b0;
        tick();
        mk(32'h3, 1'b1);
        {fr[9], fr[10], fr[11], fr[12]} = 32'h12345678;
        s0 = n_strobe;
        send(PORT, 1444);
        idle(4);
        chk("post-reset strobe", 256'(n_strobe - s0), 256'(1));
        chk("post-reset Rx0", 256'(Rx_frequency[31:0]), 256'(32'h12345678));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/high_priority_cc_v2.md
HIGH_PRIORITY_CC_V2 -- requirements
Module: high_priority_cc_v2

Interface
REQ-001 SHALL provide parameter PORT, default 16'd1027, UDP destination port accepted.
REQ-002 SHALL provide parameter NR, default 8, range 1..16, receiver DDC channel count.
REQ-003 SHALL provide parameter NT, default 1, range 1..4, transmitter channel count.
REQ-004 SHALL have a single clock and asynchronous active-high reset: clock input 1 system clock; reset input 1 async active-high reset.
REQ-005 to_port  input  16  destination port of current UDP frame.
REQ-006 udp_rx_active  input  1  high while frame payload bytes are presented, one per clock.
REQ-007 udp_rx_data  input  8  payload byte.
REQ-008 HW_timeout  input  1  host watchdog expiry.
REQ-009 run  output  1;  PC_PTT  output  NT;  CWX, Dot, Dash  output  1 each.
REQ-010 Rx_frequency  output  32*NR  flattened, channel i at [32i+31:32i].
REQ-011 Tx_frequency  output  32*NT;  drive_level  output  8*NT.
REQ-012 Alex_data  output  48;  Attenuator0, Attenuator1  output  5 each.
REQ-013 Open_Collector, User_Outputs, Mercury_Attenuator, DLE_outputs  output  8 each.
REQ-014 update_strobe  output  1  one-cycle pulse on commit.
REQ-015 short_frame  output  1  one-cycle pulse on discarded truncated frame.
REQ-016 seq_error  output  1 pulse;  seq_error_count  output  16.
REQ-017 HW_reset  output  1  payload-in-progress indicator.

Function
REQ-018 SHALL run FSM IDLE -> PAYLOAD -> COMMIT -> IDLE; PAYLOAD entered on first byte with udp_rx_active && to_port==PORT, that byte being offset 0.
REQ-019 SHALL keep 11-bit byte offset; bytes 0-3 = sequence number MSB first.
REQ-020 SHALL capture into shadow registers only: byte 4 bit0 run, bits[k+1] PC_PTT[k]; byte 5 bits[2:0] CWX/Dot/Dash; Rx_frequency[i] at 9+4i..12+4i MSB first; Tx_frequency[k] at 329+4k..332+4k; drive_level[k] at 345+k; 1400 DLE_outputs, 1401 Open_Collector, 1402 User_Outputs, 1403 Mercury_Attenuator; Alex_data[47:0] at 1430..1435 MSB first; 1442 Attenuator1=data[4:0]; 1443 Attenuator0=data[4:0].
REQ-021 SHALL enter COMMIT on the clock after offset 1443 is captured; in COMMIT all shadows copy to outputs simultaneously and update_strobe pulses (latency one cycle after byte 1443).
REQ-022 SHALL ignore bytes beyond 1443; return to IDLE only after udp_rx_active low.
REQ-023 SHALL, if udp_rx_active drops before offset 1443, discard the shadow, pulse short_frame, leave outputs unchanged, return to IDLE.
REQ-024 SHALL ignore frames with to_port!=PORT entirely.
REQ-025 HW_timeout SHALL clear run on the next edge in any state; HW_timeout has priority over a simultaneous COMMIT for run only.
REQ-026 HW_reset SHALL equal (offset>4 && udp_rx_active && in PAYLOAD), combinational.

Reset
REQ-027 Reset SHALL force IDLE, offset 0, all outputs and shadows to 0, seq_error_count 0, first-frame flag set; reset mid-frame discards that frame without commit.

Configuration
REQ-028 With SEQ_CHECK_EN defined: first committed frame after reset loads expected=seq+1; subsequent commits with seq!=expected pulse seq_error with update_strobe and increment seq_error_count, saturating at 16'hFFFF; frame still commits; expected=seq+1 mod 2^32.
REQ-029 Without SEQ_CHECK_EN: no sequence logic; seq_error and seq_error_count tied to 0.

Verification
REQ-030 Full 1444-byte frame to 1027, Rx0=0x00D59F80, byte 345=0x80 -> Rx_frequency[31:0]=0x00D59F80, drive_level=0x80, update_strobe one pulse one cycle after byte 1443.
REQ-031 Frame truncated at 700 bytes -> short_frame pulse, all outputs hold previous values, no update_strobe.
REQ-032 Frame to port 1025 -> no output change, HW_reset stays 0.
REQ-033 SEQ_CHECK_EN: sequences 5,6,8 -> seq_error on third frame only, seq_error_count=1; 0xFFFFFFFF then 0 -> no error.
REQ-034 run=1 committed, then HW_timeout asserted same cycle as a COMMIT carrying run=1 -> run=0.
REQ-035 reset asserted at offset 800 -> outputs 0 immediately, following full frame commits normally.
